// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB arbiter slice.
// Tags and words carried on the common data bus.
package cdb_arbiter_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int WORD_W    = 32;
    localparam int ENTRY_W   = ROB_IDX_W + WORD_W;

    typedef logic [ROB_IDX_W-1:0] ROB_IDX_TP;
    typedef logic [WORD_W-1:0]    WORD_TP;

    localparam ROB_IDX_TP ZERO_ROB_IDX = '0;
    localparam WORD_TP    ZERO_WORD    = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LD  = 1'b1;

    typedef struct packed {
        ROB_IDX_TP src;
        WORD_TP    val;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-producer circular result queue with synchronous flush.
// Define DEBUG to trap pushes into a full queue.
module cdb_result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int Q_BIT  = 2,
    parameter int Q_SIZE = 1 << Q_BIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [Q_BIT:0]     count,
    output logic [ENTRY_W-1:0] head
);

    localparam logic [Q_BIT:0] FULL_CNT = (Q_BIT + 1)'(Q_SIZE);

    logic [ENTRY_W-1:0] mem [Q_SIZE];
    logic [Q_BIT-1:0]   hd_ptr;
    logic [Q_BIT-1:0]   tl_ptr;
    logic               do_pop;
    logic               do_push;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign head    = mem[hd_ptr];

    // Pointer, count and storage update; flush wins over a frozen pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_ptr <= '0;
            tl_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Q_SIZE; i++) mem[i] <= '0;
        end else if (flush) begin
            hd_ptr <= '0;
            tl_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (do_push) begin
                mem[tl_ptr] <= din;
                tl_ptr      <= tl_ptr + 1'b1;
            end
            if (do_pop) hd_ptr <= hd_ptr + 1'b1;
            count <= count + {{Q_BIT{1'b0}}, do_push}
                           - {{Q_BIT{1'b0}}, do_pop};
        end
    end

`ifdef DEBUG
    // Trap a producer writing into a full queue instead of dropping it.
    always @(posedge clk) begin
        if (rst_n && en && !flush && push && !do_push) begin
            $display("cdb_result_fifo: push into full queue");
            $fatal(1, "cdb_result_fifo overflow");
        end
    end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one CDB lane between ALU and load unit.
// Define CDB_ARB_STATS_EN to add grant/throttle statistics ports.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int Q_BIT           = 2,
    parameter int Q_SIZE          = 1 << Q_BIT,
    parameter int THROTTLE_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 rb,
    input  logic                 alu_valid,
    input  logic [ROB_IDX_W-1:0] alu_src,
    input  logic [WORD_W-1:0]    alu_val,
    input  logic                 ld_valid,
    input  logic [ROB_IDX_W-1:0] ld_src,
    input  logic [WORD_W-1:0]    ld_val,
    output logic                 cdb_valid,
    output logic [ROB_IDX_W-1:0] cdb_src,
    output logic [WORD_W-1:0]    cdb_val,
    output logic                 arb_throttle
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]          stat_alu_grants,
    output logic [31:0]          stat_ld_grants,
    output logic [31:0]          stat_throttle_cycles
`endif
);

    localparam logic [Q_BIT:0] FULL_CNT = (Q_BIT + 1)'(Q_SIZE);
    localparam logic [Q_BIT:0] THR_CNT  =
        (Q_BIT + 1)'(Q_SIZE - THROTTLE_MARGIN);

    logic             alu_in, ld_in;
    logic             alu_has, ld_has;
    logic             alu_cand, ld_cand;
    logic             gnt_alu, gnt_ld;
    logic             alu_push, ld_push;
    logic             alu_pop, ld_pop;
    logic             rr_ptr, rr_nxt;
    logic             thr_nxt;
    logic [Q_BIT:0]   alu_cnt, ld_cnt;
    logic [Q_BIT:0]   alu_cnt_nxt, ld_cnt_nxt;
    logic [ENTRY_W-1:0] alu_head, ld_head;
    cdb_entry_t       alu_cd, ld_cd, gnt_e;

    assign alu_in  = alu_valid && (alu_src != ZERO_ROB_IDX);
    assign ld_in   = ld_valid && (ld_src != ZERO_ROB_IDX);
    assign alu_has = alu_cnt != '0;
    assign ld_has  = ld_cnt != '0;
    assign alu_cand = alu_has || alu_in;
    assign ld_cand  = ld_has || ld_in;
    assign alu_cd = alu_has ? cdb_entry_t'(alu_head)
                            : cdb_entry_t'({alu_src, alu_val});
    assign ld_cd  = ld_has ? cdb_entry_t'(ld_head)
                           : cdb_entry_t'({ld_src, ld_val});

    // Grant selection; the pointer only flips when both sources compete.
    always_comb begin
        gnt_alu = FALSE;
        gnt_ld  = FALSE;
        rr_nxt  = rr_ptr;
        if (alu_cand && ld_cand) begin
            gnt_alu = (rr_ptr == CDB_SRC_ALU);
            gnt_ld  = (rr_ptr == CDB_SRC_LD);
            rr_nxt  = ~rr_ptr;
        end else begin
            gnt_alu = alu_cand;
            gnt_ld  = ld_cand;
        end
    end

    // Queue traffic, next counts and the throttle look-ahead.
    always_comb begin
        alu_push = alu_in && (alu_has || !gnt_alu);
        ld_push  = ld_in && (ld_has || !gnt_ld);
        alu_pop  = gnt_alu && alu_has;
        ld_pop   = gnt_ld && ld_has;
        gnt_e    = gnt_alu ? alu_cd : ld_cd;
        alu_cnt_nxt = alu_cnt
            + {{Q_BIT{1'b0}}, alu_push && (alu_cnt != FULL_CNT || alu_pop)}
            - {{Q_BIT{1'b0}}, alu_pop};
        ld_cnt_nxt = ld_cnt
            + {{Q_BIT{1'b0}}, ld_push && (ld_cnt != FULL_CNT || ld_pop)}
            - {{Q_BIT{1'b0}}, ld_pop};
        thr_nxt = (alu_cnt_nxt >= THR_CNT) || (ld_cnt_nxt >= THR_CNT);
    end

    cdb_result_fifo #(.Q_BIT(Q_BIT), .Q_SIZE(Q_SIZE)) u_alu_q (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rdy),
        .flush (rb),
        .push  (alu_push),
        .pop   (alu_pop),
        .din   ({alu_src, alu_val}),
        .count (alu_cnt),
        .head  (alu_head)
    );

    cdb_result_fifo #(.Q_BIT(Q_BIT), .Q_SIZE(Q_SIZE)) u_ld_q (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rdy),
        .flush (rb),
        .push  (ld_push),
        .pop   (ld_pop),
        .din   ({ld_src, ld_val}),
        .count (ld_cnt),
        .head  (ld_head)
    );

    // Registered broadcast, throttle and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid    <= FALSE;
            cdb_src      <= ZERO_ROB_IDX;
            cdb_val      <= ZERO_WORD;
            arb_throttle <= FALSE;
            rr_ptr       <= CDB_SRC_ALU;
        end else if (rb) begin
            cdb_valid    <= FALSE;
            arb_throttle <= FALSE;
            rr_ptr       <= CDB_SRC_ALU;
        end else if (rdy) begin
            cdb_valid <= gnt_alu || gnt_ld;
            if (gnt_alu || gnt_ld) begin
                cdb_src <= gnt_e.src;
                cdb_val <= gnt_e.val;
            end
            arb_throttle <= thr_nxt;
            rr_ptr       <= rr_nxt;
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic [31:0] alu_grant_cnt, ld_grant_cnt, throttle_cycles;

    assign stat_alu_grants      = alu_grant_cnt;
    assign stat_ld_grants       = ld_grant_cnt;
    assign stat_throttle_cycles = throttle_cycles;

    // Saturating statistics; survive rollback, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_grant_cnt   <= '0;
            ld_grant_cnt    <= '0;
            throttle_cycles <= '0;
        end else if (rdy) begin
            if (!rb && gnt_alu && alu_grant_cnt != '1)
                alu_grant_cnt <= alu_grant_cnt + 1'b1;
            if (!rb && gnt_ld && ld_grant_cnt != '1)
                ld_grant_cnt <= ld_grant_cnt + 1'b1;
            if (arb_throttle && throttle_cycles != '1)
                throttle_cycles <= throttle_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter.
// Expected results queue per source at drive time, popped on broadcast.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] src;
        logic [WORD_W-1:0]    val;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 rdy;
    logic                 rb;
    logic                 alu_valid;
    logic [ROB_IDX_W-1:0] alu_src;
    logic [WORD_W-1:0]    alu_val;
    logic                 ld_valid;
    logic [ROB_IDX_W-1:0] ld_src;
    logic [WORD_W-1:0]    ld_val;
    logic                 cdb_valid;
    logic [ROB_IDX_W-1:0] cdb_src;
    logic [WORD_W-1:0]    cdb_val;
    logic                 arb_throttle;
`ifdef CDB_ARB_STATS_EN
    logic [31:0]          stat_alu_grants;
    logic [31:0]          stat_ld_grants;
    logic [31:0]          stat_throttle_cycles;
    logic [31:0]          stat_snap;
`endif

    exp_t                 exp_alu[$];
    exp_t                 exp_ld[$];
    logic [ROB_IDX_W-1:0] log_q[$];
    int                   n_chk = 0;
    int                   n_err = 0;
    int                   alu_seen = 0;
    logic                 rdy_i = 1'b1;
    logic                 rb_i = 1'b0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .rb           (rb),
        .alu_valid    (alu_valid),
        .alu_src      (alu_src),
        .alu_val      (alu_val),
        .ld_valid     (ld_valid),
        .ld_src       (ld_src),
        .ld_val       (ld_val),
        .cdb_valid    (cdb_valid),
        .cdb_src      (cdb_src),
        .cdb_val      (cdb_val),
        .arb_throttle (arb_throttle)
`ifdef CDB_ARB_STATS_EN
        ,
        .stat_alu_grants      (stat_alu_grants),
        .stat_ld_grants       (stat_ld_grants),
        .stat_throttle_cycles (stat_throttle_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic av, input logic [3:0] as,
                        input logic [31:0] avl, input logic lv,
                        input logic [3:0] ls);
        @(negedge clk);
        rdy       = rdy_i;
        rb        = rb_i;
        alu_valid = av;
        alu_src   = as;
        alu_val   = avl;
        ld_valid  = lv;
        ld_src    = ls;
        ld_val    = 32'h8000_0000 | {28'h0, ls};
        if (rb_i) begin
            exp_alu.delete();
            exp_ld.delete();
        end else if (rdy_i) begin
            if (av && as != 4'd0) exp_alu.push_back(exp_t'({as, avl}));
            if (lv && ls != 4'd0) exp_ld.push_back(exp_t'({ls, ld_val}));
        end
    endtask

    task automatic at_edge();
        @(posedge clk);
        #3;
    endtask

    task automatic drain();
        int k;
        k = 0;
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        while ((exp_alu.size() + exp_ld.size()) != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        at_edge();
        check("drain", 64'(exp_alu.size() + exp_ld.size()), 64'd0);
    endtask

    // Monitor: consume each fresh broadcast against its source queue.
    initial begin
        logic e_rdy, e_rb, e_rst;
        exp_t e;
        forever begin
            @(posedge clk);
            e_rdy = rdy;
            e_rb  = rb;
            e_rst = rst_n;
            #2;
            if (e_rst && e_rdy && !e_rb && cdb_valid) begin
                log_q.push_back(cdb_src);
                if (cdb_val[31]) begin
                    if (exp_ld.size() == 0) begin
                        check("ld_extra", 64'(cdb_src), 64'd0);
                    end else begin
                        e = exp_ld.pop_front();
                        check("ld_cdb", 64'({cdb_src, cdb_val}), 64'(e));
                    end
                end else begin
                    alu_seen++;
                    if (exp_alu.size() == 0) begin
                        check("alu_extra", 64'(cdb_src), 64'd0);
                    end else begin
                        e = exp_alu.pop_front();
                        check("alu_cdb", 64'({cdb_src, cdb_val}), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic thr_exp [6];
        logic [3:0] ord_exp [6];
        thr_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ord_exp = '{4'd3, 4'd7, 4'd4, 4'd8, 4'd6, 4'd9};

        rst_n = 1'b0;
        rdy = 1'b1;
        rb = 1'b0;
        alu_valid = 1'b0;
        alu_src = '0;
        alu_val = '0;
        ld_valid = 1'b0;
        ld_src = '0;
        ld_val = '0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_src", 64'(cdb_src), 64'd0);
        check("rst_val", 64'(cdb_val), 64'd0);
        check("rst_thr", 64'(arb_throttle), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single uncontended ALU result.
        step(1'b1, 4'd5, 32'h1234, 1'b0, 4'd0);
        at_edge();
        check("t1_valid", 64'(cdb_valid), 64'd1);
        check("t1_src", 64'(cdb_src), 64'd5);
        check("t1_val", 64'(cdb_val), 64'h1234);
        check("t1_thr", 64'(arb_throttle), 64'd0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        at_edge();
        check("t1_idle", 64'(cdb_valid), 64'd0);
        check("t1_thr2", 64'(arb_throttle), 64'd0);

        // Three contended cycles: strict alternation.
        log_q.delete();
        step(1'b1, 4'd3, 32'h30, 1'b1, 4'd7);
        step(1'b1, 4'd4, 32'h40, 1'b1, 4'd8);
        step(1'b1, 4'd6, 32'h60, 1'b1, 4'd9);
        drain();
        check("t2_len", 64'(log_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_q.size())
                check("t2_order", 64'(log_q[i]), 64'(ord_exp[i]));
        end

        // Sustained contention builds queues and raises the throttle.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'(10 + i), 32'(16'hA000 + i), 1'b1, 4'(1 + i));
            at_edge();
            check("t3_thr", 64'(arb_throttle), 64'(thr_exp[i]));
        end
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        at_edge();
        check("t3_thr", 64'(arb_throttle), 64'(thr_exp[4]));
        at_edge();
        check("t3_thr", 64'(arb_throttle), 64'(thr_exp[5]));
        drain();

        // Rollback with queued entries and a same-cycle load.
        step(1'b1, 4'd2, 32'h20, 1'b1, 4'd12);
        step(1'b1, 4'd3, 32'h30, 1'b1, 4'd13);
        step(1'b1, 4'd4, 32'h40, 1'b1, 4'd14);
        rb_i = 1'b1;
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd9);
        rb_i = 1'b0;
        at_edge();
        check("t4_valid", 64'(cdb_valid), 64'd0);
        check("t4_thr", 64'(arb_throttle), 64'd0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        at_edge();
        check("t4_empty", 64'(cdb_valid), 64'd0);
        drain();

        // Freeze with one load entry queued.
        step(1'b1, 4'd5, 32'h55, 1'b1, 4'd6);
        at_edge();
        check("t5_first", 64'(cdb_src), 64'd5);
        rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            at_edge();
            check("t5_hold_v", 64'(cdb_valid), 64'd1);
            check("t5_hold_s", 64'(cdb_src), 64'd5);
            check("t5_hold_d", 64'(cdb_val), 64'h55);
            check("t5_hold_t", 64'(arb_throttle), 64'd0);
        end
        rdy_i = 1'b1;
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        at_edge();
        check("t5_resume_v", 64'(cdb_valid), 64'd1);
        check("t5_resume_s", 64'(cdb_src), 64'd6);
        drain();

        // Zero tag is dropped.
`ifdef CDB_ARB_STATS_EN
        stat_snap = stat_alu_grants;
`endif
        step(1'b1, 4'd0, 32'h77, 1'b0, 4'd0);
        at_edge();
        check("t6_drop", 64'(cdb_valid), 64'd0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        at_edge();
        check("t6_drop2", 64'(cdb_valid), 64'd0);
`ifdef CDB_ARB_STATS_EN
        check("t6_stat", 64'(stat_alu_grants), 64'(stat_snap));
        check("stat_alu", 64'(stat_alu_grants), 64'(alu_seen));
`endif

        // Asynchronous reset between edges.
        step(1'b1, 4'd7, 32'h70, 1'b0, 4'd0);
        at_edge();
        check("t7_pre", 64'(cdb_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        alu_valid = 1'b0;
        #1;
        check("t7_valid", 64'(cdb_valid), 64'd0);
        check("t7_src", 64'(cdb_src), 64'd0);
        check("t7_val", 64'(cdb_val), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
